// File: rtl/load_unpack_pkg.sv
// Shared FSM encoding and beat geometry helpers for the load/unpack path.
package load_unpack_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GO,
    S_XFER,
    S_WAIT_DONE,
    S_DONE
  } state_e;

  function automatic int unsigned lanes_per_beat(input int unsigned xdw, input int unsigned dw);
    return xdw / dw;
  endfunction

  function automatic int unsigned beat_bytes(input int unsigned xdw);
    return xdw / 8;
  endfunction

  function automatic int unsigned lane_bits(input int unsigned wcnt);
    return (wcnt > 1) ? $clog2(wcnt) : 1;
  endfunction

endpackage

// File: rtl/load_unpack_beat_unpack.sv
// Holding register for one external beat, emitted one DW lane per cycle.
module beat_unpack
  import load_unpack_pkg::*;
#(
  parameter int DW  = 32,
  parameter int XDW = 128
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           last_word,
  input  logic           more,
  input  logic           avail,
  input  logic [XDW-1:0] beat,
  output logic           pop,
  output logic           wr,
  output logic [DW-1:0]  wdata
);

  localparam int unsigned WCNT = lanes_per_beat(XDW, DW);
  localparam int unsigned LW   = lane_bits(WCNT);

  logic [WCNT-1:0][DW-1:0] hold_q, hold_d;
  logic                    hold_vld_q, hold_vld_d;
  logic [LW-1:0]           lane_q, lane_d;
  logic                    lane_last;

  // Refill in the same cycle the last useful lane drains, so writes never bubble.
  always_comb begin
    wr         = en && hold_vld_q;
    lane_last  = (lane_q == LW'(WCNT - 1)) || last_word;
    pop        = en && more && avail && (!hold_vld_q || (wr && lane_last));
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    lane_d     = lane_q;
    if (pop) begin
      hold_d     = beat;
      hold_vld_d = 1'b1;
      lane_d     = '0;
    end else if (wr && lane_last) begin
      hold_vld_d = 1'b0;
      lane_d     = '0;
    end else if (wr) begin
      lane_d = lane_q + LW'(1);
    end
  end

  assign wdata = hold_q[lane_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      lane_q     <= '0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      lane_q     <= lane_d;
    end
  end

endmodule

// File: rtl/load_unpack.sv
// Loads iolen DW words from an external read master into internal RAM, unpacking XDW beats.
module load_unpack
  import load_unpack_pkg::*;
#(
  parameter int AW  = 12,
  parameter int DW  = 32,
  parameter int XAW = 32,
  parameter int XDW = 128
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_data_start,
  input  logic [DW-1:0]  param_raddr,
  input  logic [AW-1:0]  param_iolen,
  output logic           rmst_fixed_location,
  output logic [XAW-1:0] rmst_read_base,
  output logic [XAW-1:0] rmst_read_length,
  output logic           rmst_go,
  input  logic           rmst_done,
  output logic           rmst_user_read_buffer,
  input  logic [XDW-1:0] rmst_user_buffer_data,
  input  logic           rmst_user_data_available,
  output logic           ram_wena,
  output logic [AW-1:0]  ram_waddr,
  output logic [DW-1:0]  ram_wdata,
  output logic           load_data_done
);

  localparam int unsigned WCNT = lanes_per_beat(XDW, DW);
  localparam int unsigned BB   = beat_bytes(XDW);

  state_e         state_q, state_d;
  logic [XAW-1:0] base_q, base_d, len_q, len_d;
  logic           go_q, go_d, done_q, done_d, done_seen_q, done_seen_d;
  logic [AW-1:0]  waddr_q, waddr_d, words_left_q, words_left_d;
  logic [AW:0]    beats_left_q, beats_left_d, nbeats;
  logic           pop, wr, en, last_word, more;

  // One extra bit so iolen near 2^AW cannot wrap while rounding up.
  assign nbeats    = ({1'b0, param_iolen} + (AW+1)'(WCNT - 1)) / (AW+1)'(WCNT);
  assign en        = (state_q == S_XFER);
  assign last_word = (words_left_q == AW'(1));
  assign more      = (beats_left_q != '0);

  beat_unpack #(.DW(DW), .XDW(XDW)) u_unpack (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .last_word (last_word),
    .more      (more),
    .avail     (rmst_user_data_available),
    .beat      (rmst_user_buffer_data),
    .pop       (pop),
    .wr        (wr),
    .wdata     (ram_wdata)
  );

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    len_d        = len_q;
    go_d         = 1'b0;
    done_d       = 1'b0;
    done_seen_d  = done_seen_q | rmst_done;
    waddr_d      = waddr_q;
    words_left_d = words_left_q;
    beats_left_d = beats_left_q;
    case (state_q)
      S_IDLE: if (load_data_start) begin
        base_d       = XAW'(param_raddr);
        len_d        = XAW'(nbeats) * XAW'(BB);
        words_left_d = param_iolen;
        beats_left_d = nbeats;
        waddr_d      = '0;
        done_seen_d  = 1'b0;
        if (param_iolen == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_GO;
          go_d    = 1'b1;
        end
      end
      S_GO: state_d = S_XFER;
      S_XFER: begin
        if (pop) beats_left_d = beats_left_q - (AW+1)'(1);
        if (wr) begin
          waddr_d      = waddr_q + AW'(1);
          words_left_d = words_left_q - AW'(1);
          if (last_word) state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: if (rmst_done || done_seen_q) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      len_q        <= '0;
      go_q         <= 1'b0;
      done_q       <= 1'b0;
      done_seen_q  <= 1'b0;
      waddr_q      <= '0;
      words_left_q <= '0;
      beats_left_q <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      len_q        <= len_d;
      go_q         <= go_d;
      done_q       <= done_d;
      done_seen_q  <= done_seen_d;
      waddr_q      <= waddr_d;
      words_left_q <= words_left_d;
      beats_left_q <= beats_left_d;
    end
  end

  assign rmst_fixed_location   = 1'b0;
  assign rmst_read_base        = base_q;
  assign rmst_read_length      = len_q;
  assign rmst_go               = go_q;
  assign rmst_user_read_buffer = pop;
  assign ram_wena              = wr;
  assign ram_waddr             = waddr_q;
  assign load_data_done        = done_q;

endmodule

// File: tb/tb_load_unpack.sv
// Directed bench for load_unpack: show-ahead read master model plus RAM write scoreboard.
module tb_load_unpack;
  localparam int AW = 12, DW = 32, XAW = 32, XDW = 128, WCNT = 4;

  logic           clk = 1'b0, rst = 1'b0;
  logic           load_data_start = 1'b0;
  logic [DW-1:0]  param_raddr = '0;
  logic [AW-1:0]  param_iolen = '0;
  logic           rmst_fixed_location, rmst_go, rmst_user_read_buffer;
  logic [XAW-1:0] rmst_read_base, rmst_read_length;
  logic           rmst_done = 1'b0;
  logic [XDW-1:0] rmst_user_buffer_data = '0;
  logic           rmst_user_data_available = 1'b0;
  logic           ram_wena, load_data_done;
  logic [AW-1:0]  ram_waddr;
  logic [DW-1:0]  ram_wdata;

  always #5 clk = ~clk;

  load_unpack #(.AW(AW), .DW(DW), .XAW(XAW), .XDW(XDW)) dut (
    .clk(clk), .rst(rst), .load_data_start(load_data_start),
    .param_raddr(param_raddr), .param_iolen(param_iolen),
    .rmst_fixed_location(rmst_fixed_location), .rmst_read_base(rmst_read_base),
    .rmst_read_length(rmst_read_length), .rmst_go(rmst_go), .rmst_done(rmst_done),
    .rmst_user_read_buffer(rmst_user_read_buffer),
    .rmst_user_buffer_data(rmst_user_buffer_data),
    .rmst_user_data_available(rmst_user_data_available),
    .ram_wena(ram_wena), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .load_data_done(load_data_done)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t            exp_q[$];
  logic [XDW-1:0] mst_q[$];
  wr_t            e;
  int             n_tests = 0, n_fail = 0;
  int             n_pop = 0, n_go = 0, n_done = 0, n_wr = 0;
  int             cyc = 0, first_wr = 0, last_wr = 0;
  bit             thr = 1'b0;
  logic           p;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Read master: pop takes effect at the edge, head/valid refresh just after it.
  always begin
    @(negedge clk);
    p = rmst_user_read_buffer;
    @(posedge clk);
    #1;
    if (p && mst_q.size() != 0) void'(mst_q.pop_front());
    rmst_user_data_available = (mst_q.size() != 0) && (!thr || $urandom_range(3) != 0);
    rmst_user_buffer_data    = (mst_q.size() != 0) ? mst_q[0] : '0;
  end

  always @(negedge clk) begin
    cyc++;
    if (rmst_user_read_buffer) n_pop++;
    if (rmst_go) n_go++;
    if (load_data_done) n_done++;
    if (ram_wena) begin
      if (n_wr == 0) first_wr = cyc;
      last_wr = cyc;
      n_wr++;
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL wr_extra: write addr 0x%0h data 0x%0h, required none", ram_waddr, ram_wdata);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(ram_waddr), 64'(e.a));
        chk("wr_data", 64'(ram_wdata), 64'(e.d));
      end
    end
  end

  task automatic clr_cnt();
    n_pop = 0; n_go = 0; n_done = 0; n_wr = 0;
  endtask

  task automatic load(input int nb, input int iolen);
    logic [XDW-1:0] beat;
    int w = 0;
    for (int b = 0; b < nb; b++) begin
      beat = {$urandom(), $urandom(), $urandom(), $urandom()};
      mst_q.push_back(beat);
      for (int l = 0; l < WCNT; l++) begin
        if (w < iolen) exp_q.push_back(wr_t'{a: AW'(w), d: beat[l*DW +: DW]});
        w++;
      end
    end
  endtask

  task automatic start(input logic [DW-1:0] ra, input logic [AW-1:0] il);
    @(negedge clk);
    param_raddr = ra; param_iolen = il; load_data_start = 1'b1;
    @(negedge clk);
    load_data_start = 1'b0;
  endtask

  task automatic wait_wr(input string tag, input bit glitch);
    for (int i = 0; i < 5000 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      load_data_start = glitch && (i == 5);
      if (glitch && i == 5) begin param_iolen = AW'(3); param_raddr = 32'hABC; end
    end
    load_data_start = 1'b0;
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic pulse_done_after(input int d);
    repeat (d) @(negedge clk);
    chk("done_early", 64'(load_data_done), 64'd0);
    rmst_done = 1'b1;
    @(negedge clk);
    rmst_done = 1'b0;
    chk("done_lat", 64'(load_data_done), 64'd1);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 200 && n_done == 0; i++) @(negedge clk);
    @(negedge clk);
    chk(tag, 64'(n_done), 64'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_go",   64'(rmst_go), 64'd0);
    chk("rst_base", 64'(rmst_read_base), 64'd0);
    chk("rst_wena", 64'(ram_wena), 64'd0);
    chk("rst_done", 64'(load_data_done), 64'd0);
    rst = 1'b1;

    // Two full beats
    clr_cnt(); load(2, 8);
    start(32'h100, AW'(8));
    chk("t1_go",    64'(rmst_go), 64'd1);
    chk("t1_base",  64'(rmst_read_base), 64'h100);
    chk("t1_len",   64'(rmst_read_length), 64'd32);
    chk("t1_fixed", 64'(rmst_fixed_location), 64'd0);
    wait_wr("t1_wr", 1'b0);
    pulse_done_after(3);
    wait_done("t1_done");
    chk("t1_ngo",  64'(n_go), 64'd1);
    chk("t1_npop", 64'(n_pop), 64'd2);
    chk("t1_nwr",  64'(n_wr), 64'd8);

    // Partial last beat, throttled source, rmst_done seen before the last write
    thr = 1'b1; clr_cnt(); load(2, 5);
    start(32'h40, AW'(5));
    chk("t2_len", 64'(rmst_read_length), 64'd32);
    rmst_done = 1'b1;
    @(negedge clk);
    rmst_done = 1'b0;
    wait_wr("t2_wr", 1'b0);
    wait_done("t2_done");
    chk("t2_npop", 64'(n_pop), 64'd2);
    chk("t2_nwr",  64'(n_wr), 64'd5);
    thr = 1'b0;

    // Zero length
    clr_cnt();
    start(32'h80, AW'(0));
    chk("t3_done", 64'(load_data_done), 64'd1);
    chk("t3_go",   64'(rmst_go), 64'd0);
    @(negedge clk);
    chk("t3_done_pulse", 64'(load_data_done), 64'd0);
    repeat (3) @(negedge clk);
    chk("t3_ngo",   64'(n_go), 64'd0);
    chk("t3_npop",  64'(n_pop), 64'd0);
    chk("t3_ndone", 64'(n_done), 64'd1);

    // Streaming throughput
    clr_cnt(); load(256, 1024);
    start(32'h0, AW'(1024));
    chk("t4_len", 64'(rmst_read_length), 64'd4096);
    wait_wr("t4_wr", 1'b0);
    pulse_done_after(2);
    wait_done("t4_done");
    chk("t4_nwr",  64'(n_wr), 64'd1024);
    chk("t4_span", 64'(last_wr - first_wr), 64'd1023);
    chk("t4_npop", 64'(n_pop), 64'd256);

    // Late rmst_done and a stray start mid-transfer
    thr = 1'b1; clr_cnt(); load(3, 12);
    start(32'h2000, AW'(12));
    wait_wr("t5_wr", 1'b1);
    chk("t5_base", 64'(rmst_read_base), 64'h2000);
    chk("t5_ngo",  64'(n_go), 64'd1);
    pulse_done_after(20);
    wait_done("t5_done");
    chk("t5_len", 64'(rmst_read_length), 64'd48);
    thr = 1'b0;

    // Reset mid-transfer, then an immediate restart
    clr_cnt(); load(4, 16);
    start(32'h300, AW'(16));
    for (int i = 0; i < 200 && n_pop < 3; i++) @(negedge clk);
    chk("t6_pops", 64'(n_pop), 64'd3);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t6_go",    64'(rmst_go), 64'd0);
    chk("t6_base",  64'(rmst_read_base), 64'd0);
    chk("t6_len",   64'(rmst_read_length), 64'd0);
    chk("t6_pop",   64'(rmst_user_read_buffer), 64'd0);
    chk("t6_wena",  64'(ram_wena), 64'd0);
    chk("t6_waddr", 64'(ram_waddr), 64'd0);
    chk("t6_wdata", 64'(ram_wdata), 64'd0);
    chk("t6_done",  64'(load_data_done), 64'd0);
    @(negedge clk);
    @(negedge clk);
    mst_q.delete(); exp_q.delete();
    clr_cnt(); load(1, 4);
    @(negedge clk);
    rst = 1'b1; param_raddr = 32'h500; param_iolen = AW'(4); load_data_start = 1'b1;
    @(negedge clk);
    load_data_start = 1'b0;
    chk("t7_go",  64'(rmst_go), 64'd1);
    chk("t7_len", 64'(rmst_read_length), 64'd16);
    wait_wr("t7_wr", 1'b0);
    pulse_done_after(2);
    wait_done("t7_done");
    chk("t7_nwr",  64'(n_wr), 64'd4);
    chk("t7_npop", 64'(n_pop), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
